// File: rtl/ram32_arbiter.sv
// Two-port arbiter in front of a 32x1 async-write RAM, with a whole-array fill engine.
// Every output is a flop; the write strobe is only raised while address and data are settled.
module ram32_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_req_i,
  input  logic       a_wr_i,
  input  logic [4:0] a_adr_i,
  input  logic       a_din_i,
  input  logic       b_req_i,
  input  logic       b_wr_i,
  input  logic [4:0] b_adr_i,
  input  logic       b_din_i,
  output logic       a_gnt_o,
  output logic       b_gnt_o,
  output logic       a_vld_o,
  output logic       b_vld_o,
  output logic       a_dout_o,
  output logic       b_dout_o,
  input  logic       clr_start_i,
  input  logic       clr_val_i,
  output logic       clr_busy_o,
  output logic [4:0] ram_adr_o,
  output logic       ram_i_o,
  output logic       ram_we_o,
  input  logic       ram_o_i
);

  typedef enum logic [2:0] {StIdle, StSetup, StWrite, StHold, StClear} state_e;

  state_e     state_q, state_d;
  logic       own_q, own_d;    // 1 = port B owns the current access
  logic       wr_q, wr_d;
  logic       last_q, last_d;  // 1 = port B was served last
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] cnt_nxt;
  logic       pick_b;

  logic       a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic       a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic       a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic       clr_busy_q, clr_busy_d;
  logic [4:0] ram_adr_q, ram_adr_d;
  logic       ram_i_q, ram_i_d;
  logic       ram_we_q, ram_we_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      own_q      <= 1'b0;
      wr_q       <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      a_dout_q   <= 1'b0;
      b_dout_q   <= 1'b0;
      clr_busy_q <= 1'b0;
      ram_adr_q  <= '0;
      ram_i_q    <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      wr_q       <= wr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_vld_q    <= a_vld_d;
      b_vld_q    <= b_vld_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
      clr_busy_q <= clr_busy_d;
      ram_adr_q  <= ram_adr_d;
      ram_i_q    <= ram_i_d;
      ram_we_q   <= ram_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start_i)              state_d = StClear;
        else if (a_req_i || b_req_i)  state_d = StSetup;
      end
      StSetup: state_d = wr_q ? StWrite : StIdle;
      StWrite: state_d = StHold;
      StHold:  state_d = StIdle;
      StClear: if (cnt_q == 7'd64) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign pick_b  = b_req_i && (!a_req_i || !last_q);
  assign cnt_nxt = cnt_q + 7'd1;

  always_comb begin
    own_d      = own_q;
    wr_d       = wr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_vld_d    = 1'b0;
    b_vld_d    = 1'b0;
    a_dout_d   = a_dout_q;
    b_dout_d   = b_dout_q;
    clr_busy_d = 1'b0;
    ram_adr_d  = ram_adr_q;
    ram_i_d    = ram_i_q;
    ram_we_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_start_i) begin
          clr_busy_d = 1'b1;
          cnt_d      = '0;
          ram_adr_d  = '0;
          ram_i_d    = clr_val_i;
        end else if (a_req_i || b_req_i) begin
          own_d     = pick_b;
          last_d    = pick_b;
          wr_d      = pick_b ? b_wr_i  : a_wr_i;
          ram_adr_d = pick_b ? b_adr_i : a_adr_i;
          ram_i_d   = pick_b ? b_din_i : a_din_i;
          a_gnt_d   = !pick_b;
          b_gnt_d   = pick_b;
        end
      end
      StSetup: begin
        if (wr_q) begin
          ram_we_d = 1'b1;
        end else if (own_q) begin
          b_dout_d = ram_o_i;
          b_vld_d  = 1'b1;
        end else begin
          a_dout_d = ram_o_i;
          a_vld_d  = 1'b1;
        end
      end
      StWrite: ;
      StHold: begin
        a_vld_d = !own_q;
        b_vld_d = own_q;
      end
      StClear: begin
        // Step k: address k/2, strobe on odd k; k=64 is the trailing strobe-low cycle.
        if (cnt_q != 7'd64) begin
          clr_busy_d = 1'b1;
          cnt_d      = cnt_nxt;
          if (!cnt_nxt[6]) begin
            ram_adr_d = cnt_nxt[5:1];
            ram_we_d  = cnt_nxt[0];
          end
        end
      end
      default: ;
    endcase
  end

  assign a_gnt_o    = a_gnt_q;
  assign b_gnt_o    = b_gnt_q;
  assign a_vld_o    = a_vld_q;
  assign b_vld_o    = b_vld_q;
  assign a_dout_o   = a_dout_q;
  assign b_dout_o   = b_dout_q;
  assign clr_busy_o = clr_busy_q;
  assign ram_adr_o  = ram_adr_q;
  assign ram_i_o    = ram_i_q;
  assign ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_ram32_arbiter.sv
// Scoreboarded bench for ram32_arbiter with a behavioural 32x1 async-write RAM.
module tb_ram32_arbiter;

  logic       clk, rst;
  logic       a_req, a_wr, a_din, b_req, b_wr, b_din;
  logic [4:0] a_adr, b_adr;
  logic       a_gnt, b_gnt, a_vld, b_vld, a_dout, b_dout;
  logic       clr_start, clr_val, clr_busy;
  logic [4:0] ram_adr;
  logic       ram_i, ram_we, ram_o;

  ram32_arbiter u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .a_req_i    (a_req),
    .a_wr_i     (a_wr),
    .a_adr_i    (a_adr),
    .a_din_i    (a_din),
    .b_req_i    (b_req),
    .b_wr_i     (b_wr),
    .b_adr_i    (b_adr),
    .b_din_i    (b_din),
    .a_gnt_o    (a_gnt),
    .b_gnt_o    (b_gnt),
    .a_vld_o    (a_vld),
    .b_vld_o    (b_vld),
    .a_dout_o   (a_dout),
    .b_dout_o   (b_dout),
    .clr_start_i(clr_start),
    .clr_val_i  (clr_val),
    .clr_busy_o (clr_busy),
    .ram_adr_o  (ram_adr),
    .ram_i_o    (ram_i),
    .ram_we_o   (ram_we),
    .ram_o_i    (ram_o)
  );

  logic mem [32];
  always @(ram_we or ram_adr or ram_i) if (ram_we) mem[ram_adr] = ram_i;
  assign ram_o = mem[ram_adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic wr; logic d;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic shadow [32];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int a_gnt_cyc, b_gnt_cyc, a_vld_cyc, busy_rise_cyc, busy_fall_cyc;
  int busy_cycles, gnt_in_busy, we_hi, we_rise, adr_bad;
  logic [4:0] we_adr, we_next_adr, prev_adr;
  logic       we_i, prev_i, we_prev, busy_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard and bus monitor
  always @(negedge clk) begin
    exp_t e;
    if (a_gnt) a_gnt_cyc = cyc;
    if (b_gnt) b_gnt_cyc = cyc;
    if (a_vld) begin
      a_vld_cyc = cyc;
      check("a_vld_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_latency", cyc - a_gnt_cyc, e.wr ? 3 : 1);
        if (!e.wr) check("a_dout", a_dout, e.d);
      end
    end
    if (b_vld) begin
      check("b_vld_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_latency", cyc - b_gnt_cyc, e.wr ? 3 : 1);
        if (!e.wr) check("b_dout", b_dout, e.d);
      end
    end
    if (clr_busy) begin
      busy_cycles++;
      if (!busy_prev) busy_rise_cyc = cyc;
      if (a_gnt || b_gnt) gnt_in_busy++;
    end else if (busy_prev) begin
      busy_fall_cyc = cyc;
    end
    busy_prev = clr_busy;
    if (ram_we) begin
      we_hi++;
      we_adr = ram_adr;
      we_i   = ram_i;
      check("no_glitch", {ram_adr, ram_i}, {prev_adr, prev_i});
      if (!we_prev) begin
        we_rise++;
        if (ram_adr != we_next_adr) adr_bad++;
        we_next_adr++;
      end
    end
    we_prev  = ram_we;
    prev_adr = ram_adr;
    prev_i   = ram_i;
  end

  task automatic clear_stats();
    busy_cycles = 0; gnt_in_busy = 0; we_hi = 0; we_rise = 0; adr_bad = 0; we_next_adr = '0;
  endtask

  task automatic access(input bit p, input bit wr, input logic [4:0] adr, input bit din);
    exp_t e;
    int n;
    e.wr = wr;
    e.d  = shadow[adr];
    if (wr) shadow[adr] = din;
    if (p) begin
      qb.push_back(e);
      b_req = 1'b1; b_wr = wr; b_adr = adr; b_din = din;
    end else begin
      qa.push_back(e);
      a_req = 1'b1; a_wr = wr; a_adr = adr; a_din = din;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? b_gnt : a_gnt) && n < 200);
    check(p ? "b_gnt_seen" : "a_gnt_seen", p ? b_gnt : a_gnt, 1);
    if (p) b_req = 1'b0;
    else   a_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", qa.size() + qb.size(), 0);
  endtask

  task automatic wait_busy(input bit lvl, input int lim);
    int n = 0;
    while (clr_busy !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", clr_busy, lvl);
  endtask

  task automatic fill_shadow(input bit v);
    for (int i = 0; i < 32; i++) shadow[i] = v;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = 1'b0; shadow[i] = 1'b0; end
    rst = 1'b1;
    {a_req, a_wr, a_din, b_req, b_wr, b_din, clr_start, clr_val} = '0;
    a_adr = '0; b_adr = '0;
    {we_prev, busy_prev, prev_i} = '0; prev_adr = '0;
    clear_stats();
    @(negedge clk);
    check("reset_outs", {a_gnt, b_gnt, a_vld, b_vld, a_dout, b_dout, clr_busy, ram_we, ram_i, ram_adr},
          0);
    @(negedge clk);
    rst = 1'b0;

    // Tie right after reset: A first, B granted off the IDLE cycle that carries A_VLD
    fork
      access(0, 0, 5'd3, 0);
      access(1, 0, 5'd4, 0);
    join
    drain();
    check("tie1_gap", b_gnt_cyc - a_gnt_cyc, 2);
    // A served alone leaves the pointer at A-last, so the next tie goes to B
    access(0, 0, 5'd0, 0);
    drain();
    fork
      access(0, 0, 5'd1, 0);
      access(1, 0, 5'd2, 0);
    join
    drain();
    check("tie2_gap", a_gnt_cyc - b_gnt_cyc, 2);

    // Write then read on A, plus a B write/read of the opposite value
    clear_stats();
    access(0, 1, 5'h13, 1);
    drain();
    check("wr_we_cycles", we_hi, 1);
    check("wr_we_adr", we_adr, 5'h13);
    check("wr_we_data", we_i, 1);
    access(0, 0, 5'h13, 0);
    drain();
    access(1, 1, 5'h0a, 1);
    access(1, 1, 5'h0a, 0);
    access(1, 0, 5'h0a, 0);
    access(0, 0, 5'h13, 0);
    drain();

    // Fill with 1
    clear_stats();
    clr_val = 1'b1; clr_start = 1'b1;
    fill_shadow(1'b1);
    wait_busy(1, 10);
    clr_start = 1'b0;
    wait_busy(0, 100);
    check("fill_busy_cycles", busy_cycles, 65);
    check("fill_we_cycles", we_hi, 32);
    check("fill_we_pulses", we_rise, 32);
    check("fill_adr_order", adr_bad, 0);
    access(0, 0, 5'd0, 0);
    access(1, 0, 5'd17, 0);
    access(0, 0, 5'd31, 0);
    drain();

    // Fill and B request raised during an A write
    clear_stats();
    access(0, 1, 5'd5, 0);
    @(negedge clk);
    check("pend_in_write", ram_we, 1);
    clr_val = 1'b0; clr_start = 1'b1;
    fill_shadow(1'b0);
    fork
      access(1, 0, 5'd5, 0);
      begin
        wait_busy(1, 10);
        clr_start = 1'b0;
        wait_busy(0, 100);
      end
    join
    drain();
    check("pend_fill_after_a", busy_rise_cyc - a_vld_cyc, 1);
    check("pend_b_after_fill", 32'(b_gnt_cyc >= busy_fall_cyc), 1);
    check("pend_no_gnt_busy", gnt_in_busy, 0);

    // Reset in the middle of a WRITE cycle
    access(0, 0, 5'd0, 0);
    drain();
    access(0, 1, 5'd9, 1);
    @(negedge clk);
    check("rst_in_write", ram_we, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs",
          {a_gnt, b_gnt, a_vld, b_vld, a_dout, b_dout, clr_busy, ram_we, ram_i, ram_adr}, 0);
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_vld_queue", qa.size(), 0);

    // Reset in the middle of a fill: the fill must not resume
    clr_val = 1'b1; clr_start = 1'b1;
    wait_busy(1, 10);
    clr_start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_in_fill", {ram_we, clr_busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (70) @(negedge clk);
    check("fill_not_resumed", busy_cycles + we_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram32_arbiter.md
RAM32_ARBITER -- requirements
Module: ram32_arbiter

Interface
REQ-001 The block SHALL have no parameters; it arbitrates one external 32x1 asynchronous-write, combinational-read RAM.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 A_REQ, B_REQ  input  1 each  access request; level, held until the matching GNT is seen.
REQ-005 A_WR, B_WR  input  1 each  1 = write, 0 = read; sampled with REQ.
REQ-006 A_ADR, B_ADR  input  5 each  RAM address; sampled with REQ.
REQ-007 A_DIN, B_DIN  input  1 each  write data; sampled with REQ.
REQ-008 A_GNT, B_GNT  output  1 each  one-cycle grant pulse.
REQ-009 A_VLD, B_VLD  output  1 each  one-cycle completion pulse, for reads and writes.
REQ-010 A_DOUT, B_DOUT  output  1 each  registered read data; updated only on that port's reads.
REQ-011 CLR_START  input  1  fill request; level, held until CLR_BUSY is seen.
REQ-012 CLR_VAL  input  1  fill value; latched when the fill starts.
REQ-013 CLR_BUSY  output  1  high for the whole fill.
REQ-014 RAM_ADR  output  5  to RAM ADR4..ADR0.
REQ-015 RAM_I  output  1  to RAM I.
REQ-016 RAM_WE  output  1  to RAM WE.
REQ-017 RAM_O  input  1  from RAM O.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, WRITE, HOLD and CLEAR; every output SHALL be a register output.
REQ-019 In IDLE, priority SHALL be: CLR_START first, then round-robin between A and B.
- Single requester: grant it.
- Both requesting: grant the port not served last.
REQ-020 The round-robin pointer SHALL update only on an A/B grant, never on a fill.
REQ-021 On a grant, the winner's WR, ADR and DIN SHALL be latched; its GNT SHALL go high for exactly the next cycle; state SHALL go to SETUP.
- RAM_ADR and RAM_I SHALL take the latched values in that same cycle.
REQ-022 Read sequence: SETUP (RAM_WE=0), then at the end of SETUP capture RAM_O into the port's DOUT, pulse VLD for one cycle, return to IDLE.
- GNT-to-VLD latency SHALL be 1 cycle.
REQ-023 Write sequence: SETUP (RAM_WE=0), WRITE (RAM_WE=1), HOLD (RAM_WE=0, address and data unchanged), then IDLE with VLD pulsed in the cycle after HOLD.
- GNT-to-VLD latency SHALL be 3 cycles.
REQ-024 RAM_ADR and RAM_I SHALL stay stable from SETUP through HOLD.
- RAM_WE SHALL never be high in a cycle where RAM_ADR or RAM_I changes.
REQ-025 REQ, WR, ADR and DIN SHALL be ignored outside IDLE.
- A request still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-026 Fill sequence: CLR_VAL latched, CLR_BUSY high, counter=0.
- For each address 0..31: one cycle with RAM_WE=0 and the new address, then one cycle with RAM_WE=1.
- After address 31, one final cycle with RAM_WE=0.
- CLR_BUSY SHALL then drop, giving 65 CLR_BUSY cycles in total, and the FSM SHALL return to IDLE.
REQ-027 During a fill, no GNT SHALL be issued; A/B requests SHALL wait.
REQ-028 A CLR_START asserted during an A/B access SHALL be served at the next IDLE, ahead of any pending A/B request.
REQ-029 Simultaneous A and B requests with the pointer at A-last SHALL grant B; the other port SHALL be granted in the first IDLE cycle after completion.

Reset
REQ-030 RST high SHALL immediately force the following, regardless of CLK:
- state IDLE; RAM_WE=0; RAM_ADR=0; RAM_I=0;
- all GNT, VLD and CLR_BUSY = 0; A_DOUT = B_DOUT = 0;
- round-robin pointer = B-last, so A wins the first tie.
REQ-031 Reset during WRITE or CLEAR SHALL deassert RAM_WE asynchronously and abort the operation.
- No VLD SHALL be issued for the aborted access.
- The fill SHALL not resume after reset.
REQ-032 After RST falls, the first grant SHALL be possible at the first rising CLK edge.

Verification
REQ-033 Write then read, A: A writes 1 to address 0x13, then reads 0x13.
- Required: RAM_WE high exactly 1 cycle with RAM_ADR=0x13, RAM_I=1.
- Required: A_VLD 3 cycles after the write A_GNT and 1 cycle after the read A_GNT; A_DOUT=1.
REQ-034 Tie: A and B request reads together right after reset.
- Required: A granted first, B granted in the first IDLE cycle after A_VLD.
- Repeating the tie SHALL grant B first.
REQ-035 Fill: CLR_START with CLR_VAL=1.
- Required: CLR_BUSY high 65 cycles, 32 one-cycle RAM_WE pulses at addresses 0..31 ascending.
- Required: reads of addresses 0, 17 and 31 return 1.
REQ-036 Fill pending: CLR_START and B_REQ raised while an A write is in WRITE.
- Required: the fill starts after A completes, and B_GNT appears only after CLR_BUSY falls.
REQ-037 Reset mid-operation: RST asserted mid-cycle during WRITE.
- Required: RAM_WE drops before the next CLK edge, no A_VLD, all outputs at reset values.
REQ-038 No-glitch check: across all scenarios, a monitor SHALL flag any cycle where RAM_WE=1 and RAM_ADR or RAM_I differs from its value in the previous cycle.
